// File: rtl/rsa_host_if_if.sv
// Host register-bus bundle for the RSA host front-end.
// The master drives writes and the address; the slave returns read data and irq.
interface rsa_host_if_if;
   logic       wr_en;
   logic [2:0] addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       irq;

   modport master (
      output wr_en, addr, wr_data,
      input  rd_data, irq
   );

   modport slave (
      input  wr_en, addr, wr_data,
      output rd_data, irq
   );
endinterface

// File: rtl/rsa_host_if.sv
// Host-side register front-end for the modular-exponentiation core.
// It holds the operands and exponent, and sequences each run as follows:
// a one-cycle core reset, then enable until eoc or timeout, then result capture.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | core disabled; operand writes and start accepted
// CLEAR   | one cycle with core_rstb low; timeout counter already zeroed
// RUN     | en high; waiting for eoc; timeout counter advancing
// CAPTURE | result latched; en low; done raised on exit to IDLE
module rsa_host_if #(
   parameter int TIMEOUT = 200
) (
   input  logic          clk,
   input  logic          rstb,
   rsa_host_if_if.slave  host,
   output logic          core_rstb,
   output logic          en,
   output logic [8:0]    expE,
   output logic [7:0]    plain,
   output logic [7:0]    modulus,
   output logic [7:0]    const_r2,
   input  logic          eoc,
   input  logic [7:0]    result
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_RUN     = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] plain_q, plain_d;
   logic [7:0] modulus_q, modulus_d;
   logic [7:0] const_r2_q, const_r2_d;
   logic [8:0] exp_q, exp_d;
   logic [7:0] result_q, result_d;
   logic [7:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       en_q, en_d;
   logic       clr_q, clr_d;

   logic       wr_ctrl;
   logic       start;
   logic       clear;
   logic       idle;
   logic [7:0] cnt_inc;
   logic       tmo_hit;

   // Decode control writes and the saturating timeout comparison.
   always_comb begin
      wr_ctrl = host.wr_en && (host.addr == 3'd5);
      start   = wr_ctrl && host.wr_data[0];
      clear   = wr_ctrl && host.wr_data[1];
      idle    = (state_q == S_IDLE);
      cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
      tmo_hit = (cnt_inc >= TMO);
   end

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; eoc takes priority over a coincident timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_CLEAR;
         S_CLEAR:   state_d = S_RUN;
         S_RUN: begin
            if (eoc)          state_d = S_CAPTURE;
            else if (tmo_hit) state_d = S_IDLE;
         end
         S_CAPTURE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM outputs: counter, status flags, result capture, registered en and core reset.
   always_comb begin
      cnt_d    = cnt_q;
      done_d   = done_q;
      err_d    = err_q;
      result_d = result_q;
      if (clear) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d  = 8'd0;
               done_d = 1'b0;
               err_d  = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (eoc)          result_d = result;
            else if (tmo_hit) err_d    = 1'b1;
         end
         S_CAPTURE: done_d = 1'b1;
         default: ;
      endcase
      en_d  = (state_d == S_RUN);
      clr_d = (state_d == S_CLEAR);
   end

   // Operand and exponent writes, accepted only while idle.
   always_comb begin
      plain_d    = plain_q;
      modulus_d  = modulus_q;
      const_r2_d = const_r2_q;
      exp_d      = exp_q;
      if (host.wr_en && idle) begin
         case (host.addr)
            3'd0:    plain_d     = host.wr_data;
            3'd1:    modulus_d   = host.wr_data;
            3'd2:    const_r2_d  = host.wr_data;
            3'd3:    exp_d[7:0]  = host.wr_data;
            3'd4:    exp_d[8]    = host.wr_data[0];
            default: ;
         endcase
      end
   end

   // Register file, flags, counter and output flops.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         plain_q    <= 8'd0;
         modulus_q  <= 8'd0;
         const_r2_q <= 8'd0;
         exp_q      <= 9'd0;
         result_q   <= 8'd0;
         cnt_q      <= 8'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         en_q       <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         plain_q    <= plain_d;
         modulus_q  <= modulus_d;
         const_r2_q <= const_r2_d;
         exp_q      <= exp_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         en_q       <= en_d;
         clr_q      <= clr_d;
      end
   end

   // Read mux; control reads back as zero.
   always_comb begin
      case (host.addr)
         3'd0:    host.rd_data = plain_q;
         3'd1:    host.rd_data = modulus_q;
         3'd2:    host.rd_data = const_r2_q;
         3'd3:    host.rd_data = exp_q[7:0];
         3'd4:    host.rd_data = {7'd0, exp_q[8]};
         3'd6:    host.rd_data = {5'd0, err_q, done_q, !idle};
         3'd7:    host.rd_data = result_q;
         default: host.rd_data = 8'd0;
      endcase
   end

   // The core reset follows rstb directly so that it is held low during reset and released together with it.
   assign core_rstb = rstb & ~clr_q;
   assign en        = en_q;
   assign host.irq  = done_q | err_q;
   assign expE      = exp_q;
   assign plain     = plain_q;
   assign modulus   = modulus_q;
   assign const_r2  = const_r2_q;

endmodule
